sipo_frame_controller: RTL and testbench

Framed serial receiver that sequences an internal DATA_WIDTH-bit left-shift SIPO stage. It detects a start bit, shifts exactly DATA_WIDTH data bits (MSB first), checks optional even parity and the stop bit, and presents the word through a valid/ready output buffer. It sits between a raw serial line and any word-oriented consumer. It replaces free-running shifting with bit-counted, framed capture.

---
 rtl/sipo_frame_controller.sv | 128 ++++++++++++
 tb/tb_sipo_frame_controller.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sipo_frame_controller.sv
// sipo_frame_controller
//
// Framed serial receiver. It waits for a low start bit and then shifts
// exactly DATA_WIDTH data bits, MSB first, into a left-shift SIPO stage.
// When PARITY_EN is set, an even-parity bit follows the data bits. The
// stop bit closes the frame. A good word is presented through a single
// valid/ready output buffer.
//
// Ports:
//   clk        - single clock; every rising edge samples exactly one bit
//   clear      - asynchronous, active-high reset
//   serial_in  - serial line (idle high, start bit low, stop bit high)
//   data_ready - consumer accepts data_out when high together with data_valid
//   data_out   - last good word; the first data bit received is the MSB
//   data_valid - data_out holds an unconsumed word
//   parity_err - one-cycle pulse: frame dropped for bad parity
//   frame_err  - one-cycle pulse: frame dropped because the stop bit was 0
//   overrun    - one-cycle pulse: good frame dropped because the buffer was full
//   busy       - high whenever a frame is in progress
module sipo_frame_controller #(
  parameter int DATA_WIDTH = 4,
  parameter bit PARITY_EN  = 1'b1
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  serial_in,
  input  logic                  data_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  overrun,
  output logic                  busy
);

  localparam int CW = $clog2(DATA_WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                state;
  logic [CW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  parity_bit;
  logic                  parity_ok;

  // Even parity: the data bits XORed with the parity bit must come to zero.
  // Without a parity bit every frame passes this check.
  assign parity_ok = PARITY_EN ? ~(^shift_reg ^ parity_bit) : 1'b1;

  // Frame sequencer and output buffer. The error and overrun pulses default
  // low on every edge, so each lasts exactly one cycle. A consumed word
  // drops data_valid, unless a good frame reloads the buffer on the same edge.
  // That reload is a later non-blocking assignment, so it takes precedence.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;

      if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (!serial_in) begin
            state     <= DATA;
            bit_cnt   <= '0;
            shift_reg <= '0;
            busy      <= 1'b1;
          end
        end

        DATA: begin
          shift_reg <= {shift_reg[DATA_WIDTH-2:0], serial_in};
          bit_cnt   <= bit_cnt + CW'(1);
          if (bit_cnt == CW'(DATA_WIDTH - 1)) begin
            state <= PARITY_EN ? PARITY : STOP;
          end
        end

        PARITY: begin
          parity_bit <= serial_in;
          state      <= STOP;
        end

        STOP: begin
          state <= IDLE;
          busy  <= 1'b0;
          // The stop bit takes priority over parity, so each frame raises
          // at most one error pulse.
          if (!serial_in) begin
            frame_err <= 1'b1;
          end else if (!parity_ok) begin
            parity_err <= 1'b1;
          end else if (!data_valid || data_ready) begin
            data_out   <= shift_reg;
            data_valid <= 1'b1;
          end else begin
            overrun <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sipo_frame_controller.sv
// tb_sipo_frame_controller
//
// Directed bench for sipo_frame_controller. There are two instances:
//   dut4 - DATA_WIDTH=4, PARITY_EN=1
//   dut8 - DATA_WIDTH=8, PARITY_EN=0
// Inputs are driven on the falling edge. Outputs are sampled on the falling
// edge, half a cycle after the rising edge that updated them.
module tb_sipo_frame_controller;

  logic       clk;
  logic       clear;
  logic       serial_in;
  logic       data_ready;
  logic [3:0] data_out;
  logic       data_valid;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  logic       serial8;
  logic       ready8;
  logic [7:0] data_out8;
  logic       valid8;
  logic       parity_err8;
  logic       frame_err8;
  logic       overrun8;
  logic       busy8;

  int total;
  int bad;

  sipo_frame_controller #(.DATA_WIDTH(4), .PARITY_EN(1'b1)) dut4 (
    .clk        (clk),
    .clear      (clear),
    .serial_in  (serial_in),
    .data_ready (data_ready),
    .data_out   (data_out),
    .data_valid (data_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  sipo_frame_controller #(.DATA_WIDTH(8), .PARITY_EN(1'b0)) dut8 (
    .clk        (clk),
    .clear      (clear),
    .serial_in  (serial8),
    .data_ready (ready8),
    .data_out   (data_out8),
    .data_valid (valid8),
    .parity_err (parity_err8),
    .frame_err  (frame_err8),
    .overrun    (overrun8),
    .busy       (busy8)
  );

  // 10-unit clock; rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one bit into dut4, let one rising edge sample it, and return at
  // the following falling edge.
  task automatic send_bit(input logic b);
    serial_in = b;
    @(negedge clk);
  endtask

  // Send a whole frame to dut4: start, four data bits MSB first, parity, stop.
  task automatic send_frame(input logic [3:0] d, input logic p, input logic s);
    send_bit(1'b0);
    for (int i = 3; i >= 0; i--) send_bit(d[i]);
    send_bit(p);
    send_bit(s);
    serial_in = 1'b1;
  endtask

  // Let one idle edge pass, with the line held high.
  task automatic idle_cycle();
    serial_in = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    clear = 1'b1;
    serial_in = 1'b1;
    serial8 = 1'b1;
    data_ready = 1'b0;
    ready8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++; if (data_out !== 4'h0) begin bad++; $display("[TB] FAIL reset_data_out: got %h want 0", data_out); end
    total++; if (data_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b want 0", data_valid); end
    total++; if ({parity_err, frame_err, overrun} !== 3'b000) begin bad++; $display("[TB] FAIL reset_pulses: got %b want 000", {parity_err, frame_err, overrun}); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    total++; if ({data_out8, valid8, busy8} !== 10'h0) begin bad++; $display("[TB] FAIL reset_dut8: got %h want 0", {data_out8, valid8, busy8}); end
    clear = 1'b0;
    idle_cycle();
    idle_cycle();
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_basic_frame();
    data_ready = 1'b0;
    send_bit(1'b0);
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL basic_busy_after_start: got %b want 1", busy); end
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    send_bit(1'b1);
    total++; if (data_valid !== 1'b0) begin bad++; $display("[TB] FAIL basic_valid_early: got %b want 0", data_valid); end
    send_bit(1'b1);
    serial_in = 1'b1;
    total++; if (data_out !== 4'b1011) begin bad++; $display("[TB] FAIL basic_data: got %b want 1011", data_out); end
    total++; if (data_valid !== 1'b1) begin bad++; $display("[TB] FAIL basic_valid: got %b want 1", data_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL basic_busy_end: got %b want 0", busy); end
    total++; if ({parity_err, frame_err, overrun} !== 3'b000) begin bad++; $display("[TB] FAIL basic_no_err: got %b want 000", {parity_err, frame_err, overrun}); end
    idle_cycle();
    idle_cycle();
    total++; if (data_valid !== 1'b1 || data_out !== 4'b1011) begin bad++; $display("[TB] FAIL basic_hold: got %b/%b want 1/1011", data_valid, data_out); end
    data_ready = 1'b1;
    idle_cycle();
    data_ready = 1'b0;
    total++; if (data_valid !== 1'b0) begin bad++; $display("[TB] FAIL basic_consume: got %b want 0", data_valid); end
  endtask

  task automatic test_parity_err();
    send_frame(4'b1011, 1'b0, 1'b1);
    total++; if (parity_err !== 1'b1) begin bad++; $display("[TB] FAIL parity_pulse: got %b want 1", parity_err); end
    total++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin bad++; $display("[TB] FAIL parity_other: got %b%b want 00", frame_err, overrun); end
    total++; if (data_valid !== 1'b0 || data_out !== 4'b1011) begin bad++; $display("[TB] FAIL parity_drop: got %b/%b want 0/1011", data_valid, data_out); end
    idle_cycle();
    total++; if (parity_err !== 1'b0) begin bad++; $display("[TB] FAIL parity_pulse_len: got %b want 0", parity_err); end
  endtask

  task automatic test_frame_err();
    send_frame(4'b0110, 1'b0, 1'b0);
    total++; if (frame_err !== 1'b1) begin bad++; $display("[TB] FAIL frame_pulse: got %b want 1", frame_err); end
    total++; if (parity_err !== 1'b0) begin bad++; $display("[TB] FAIL frame_no_parity: got %b want 0", parity_err); end
    total++; if (data_valid !== 1'b0) begin bad++; $display("[TB] FAIL frame_valid: got %b want 0", data_valid); end
    idle_cycle();
    total++; if (frame_err !== 1'b0 || busy !== 1'b0) begin bad++; $display("[TB] FAIL frame_after: got err=%b busy=%b want 0/0", frame_err, busy); end
  endtask

  task automatic test_overrun();
    data_ready = 1'b0;
    send_frame(4'b1011, 1'b1, 1'b1);
    total++; if (data_valid !== 1'b1 || data_out !== 4'b1011) begin bad++; $display("[TB] FAIL ovr_first: got %b/%b want 1/1011", data_valid, data_out); end
    send_frame(4'b0110, 1'b0, 1'b1);
    total++; if (overrun !== 1'b1) begin bad++; $display("[TB] FAIL ovr_pulse: got %b want 1", overrun); end
    total++; if (data_out !== 4'b1011 || data_valid !== 1'b1) begin bad++; $display("[TB] FAIL ovr_keep: got %b/%b want 1/1011", data_valid, data_out); end
    idle_cycle();
    total++; if (overrun !== 1'b0) begin bad++; $display("[TB] FAIL ovr_pulse_len: got %b want 0", overrun); end
    data_ready = 1'b1;
    idle_cycle();
    data_ready = 1'b0;
    total++; if (data_valid !== 1'b0) begin bad++; $display("[TB] FAIL ovr_drain: got %b want 0", data_valid); end
  endtask

  task automatic test_back_to_back_drain();
    data_ready = 1'b0;
    send_frame(4'b1011, 1'b1, 1'b1);
    send_bit(1'b0);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    send_bit(1'b0);
    total++; if (data_valid !== 1'b1 || data_out !== 4'b1011) begin bad++; $display("[TB] FAIL b2b_held: got %b/%b want 1/1011", data_valid, data_out); end
    data_ready = 1'b1;
    send_bit(1'b1);
    data_ready = 1'b0;
    serial_in = 1'b1;
    total++; if (data_out !== 4'b0110) begin bad++; $display("[TB] FAIL b2b_data: got %b want 0110", data_out); end
    total++; if (data_valid !== 1'b1) begin bad++; $display("[TB] FAIL b2b_valid: got %b want 1", data_valid); end
    total++; if (overrun !== 1'b0) begin bad++; $display("[TB] FAIL b2b_no_ovr: got %b want 0", overrun); end
    data_ready = 1'b1;
    idle_cycle();
    data_ready = 1'b0;
    total++; if (data_valid !== 1'b0) begin bad++; $display("[TB] FAIL b2b_drain: got %b want 0", data_valid); end
  endtask

  task automatic test_reset_mid_frame();
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    #2 clear = 1'b1;
    #1;
    total++; if ({data_out, data_valid, parity_err, frame_err, overrun, busy} !== 9'h0) begin bad++; $display("[TB] FAIL midreset_outputs: got %h want 0", {data_out, data_valid, parity_err, frame_err, overrun, busy}); end
    serial_in = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    send_frame(4'b0101, 1'b0, 1'b1);
    total++; if (data_out !== 4'b0101 || data_valid !== 1'b1) begin bad++; $display("[TB] FAIL midreset_frame: got %b/%b want 1/0101", data_valid, data_out); end
    total++; if ({parity_err, frame_err, overrun} !== 3'b000) begin bad++; $display("[TB] FAIL midreset_no_err: got %b want 000", {parity_err, frame_err, overrun}); end
    data_ready = 1'b1;
    idle_cycle();
    data_ready = 1'b0;
  endtask

  task automatic test_held_low();
    for (int i = 0; i < 7; i++) send_bit(1'b0);
    total++; if (frame_err !== 1'b1) begin bad++; $display("[TB] FAIL low_frame_err: got %b want 1", frame_err); end
    send_bit(1'b0);
    total++; if (busy !== 1'b1 || frame_err !== 1'b0) begin bad++; $display("[TB] FAIL low_restart: got busy=%b err=%b want 1/0", busy, frame_err); end
    serial_in = 1'b1;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    idle_cycle();
  endtask

  task automatic test_w8_no_parity();
    logic [7:0] word;
    int busy_cycles;
    word = 8'hA5;
    busy_cycles = 0;
    serial8 = 1'b0;
    @(negedge clk);
    if (busy8 === 1'b1) busy_cycles++;
    for (int i = 7; i >= 0; i--) begin
      serial8 = word[i];
      @(negedge clk);
      if (busy8 === 1'b1) busy_cycles++;
    end
    total++; if (valid8 !== 1'b0) begin bad++; $display("[TB] FAIL w8_valid_early: got %b want 0", valid8); end
    serial8 = 1'b1;
    @(negedge clk);
    if (busy8 === 1'b1) busy_cycles++;
    total++; if (data_out8 !== 8'hA5 || valid8 !== 1'b1) begin bad++; $display("[TB] FAIL w8_data: got %b/%h want 1/a5", valid8, data_out8); end
    total++; if ({parity_err8, frame_err8, overrun8} !== 3'b000) begin bad++; $display("[TB] FAIL w8_no_err: got %b want 000", {parity_err8, frame_err8, overrun8}); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (busy8 === 1'b1) busy_cycles++;
    end
    total++; if (busy_cycles != 9) begin bad++; $display("[TB] FAIL w8_busy_cycles: got %0d want 9", busy_cycles); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_basic_frame();
    test_parity_err();
    test_frame_err();
    test_overrun();
    test_back_to_back_drain();
    test_reset_mid_frame();
    test_held_low();
    test_w8_no_parity();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
